// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the two-digit timer sequencer: the FSM state
// encoding, the terminal digit values the counters report against, and a
// helper that turns a raw preset into the value actually loaded into the
// digit counters.
// ---------------------------------------------------------------------------
package timer_pkg;

   // FSM state encoding, also visible on the state output of the top level.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      RUN     = 3'd2,
      PAUSE   = 3'd3,
      EXPIRED = 3'd4
   } timerState_e;

   // Terminal values a digit counter compares against when raising cnt_done.
   localparam logic [3:0] DIGIT_MIN     = 4'h0;
   localparam logic [3:0] DIGIT_MAX_BCD = 4'h9;
   localparam logic [3:0] DIGIT_MAX_HEX = 4'hF;

   // Both digits sitting on their terminal value at the same time.
   localparam logic [1:0] DONE_BOTH = 2'b11;

   // Value pushed into the counters when the sequence is aborted.
   localparam logic [7:0] CLEAR_VAL = 8'h00;

   // A BCD digit can never legally exceed 9, so anything larger saturates.
   function automatic logic [3:0] clampBcdDigit(input logic [3:0] digit);
      return (digit > DIGIT_MAX_BCD) ? DIGIT_MAX_BCD : digit;
   endfunction

   // Load value for the counters: per-digit clamp in BCD mode, raw in hex.
   function automatic logic [7:0] loadValue(input logic [7:0] raw, input logic bcd);
      return bcd ? {clampBcdDigit(raw[7:4]), clampBcdDigit(raw[3:0])} : raw;
   endfunction

endpackage

// File: rtl/timer_seq_ctrl_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Prescaler for the timer sequencer. Produces a one-cycle tick every
// TICK_DIV counting cycles. The count freezes while hold is high and
// returns to zero on clr, so a paused sequence resumes mid-period.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset, zeroes the count
//   clr    in   zero the count (used while the sequencer loads)
//   hold   in   freeze the count and suppress tick
//   tick   out  one-cycle pulse on the last cycle of each period
//
// TICK_DIV must be at least 2: the sequencer registers its enables one
// cycle after a tick, so back-to-back ticks would act on stale digits.
// ---------------------------------------------------------------------------
module tick_gen #(
   parameter int unsigned TICK_DIV = 100000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic hold,
   output logic tick
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count;

   // Period counter: wraps on the last cycle of the period, stands still
   // while held, and restarts from zero whenever the sequencer reloads.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (!hold) begin
         if (count == LAST_COUNT) begin
            count <= '0;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

   // The tick is a decode of the count, so the first one lands on the
   // TICK_DIV-th counting cycle after a clear.
   assign tick = !hold && !clr && (count == LAST_COUNT);

endmodule

// File: rtl/timer_seq_ctrl.sv
// ---------------------------------------------------------------------------
// timer_seq_ctrl
// Sequencer for a two-digit (tens/ones) count-up/count-down timer. It does
// not hold the digits itself: it drives load and per-digit enable strobes
// to two external digit counters and watches their terminal flags.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   start         in   pulse: begin from IDLE, resume from PAUSE,
//                      restart from RUN or EXPIRED
//   pause         in   pulse: freeze counting while in RUN
//   clear         in   pulse: abort, zero the digits, return to IDLE
//   dir           in   1 = count up, 0 = count down (captured on load)
//   mode_bcd      in   1 = BCD digits, 0 = hex digits (captured on load)
//   preset[7:0]   in   start value {tens, ones} (captured on load)
//   cnt_load      out  load strobe to both digit counters
//   cnt_load_val  out  load value {tens, ones}
//   cnt_en[1:0]   out  per-digit count enable, bit0 = ones, bit1 = tens
//   cnt_updown    out  latched direction for the counters
//   cnt_mode      out  latched BCD/hex mode for the counters
//   cnt_done[1:0] in   per-digit terminal flag from the counters
//   state[2:0]    out  current FSM state
//   expired       out  high while in EXPIRED
//
// Input priority in every state is clear, then start, then pause.
// ---------------------------------------------------------------------------
module timer_seq_ctrl
   import timer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   input  logic       dir,
   input  logic       mode_bcd,
   input  logic [7:0] preset,
   output logic       cnt_load,
   output logic [7:0] cnt_load_val,
   output logic [1:0] cnt_en,
   output logic       cnt_updown,
   output logic       cnt_mode,
   input  logic [1:0] cnt_done,
   output logic [2:0] state,
   output logic       expired
);

   timerState_e curState;
   logic        tick;
   logic        prescaleClr;
   logic        prescaleHold;
   logic [7:0]  presetLoad;

   // Preset as it will appear on cnt_load_val, clamped per digit in BCD.
   assign presetLoad = loadValue(preset, mode_bcd);

   // The prescaler restarts during LOAD and only advances in RUN, so a
   // pause keeps the partial period and a resume picks it up where it was.
   assign prescaleClr  = (curState == LOAD);
   assign prescaleHold = (curState != RUN);

   tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) uTickGen (
      .clk  (clk),
      .reset(reset),
      .clr  (prescaleClr),
      .hold (prescaleHold),
      .tick (tick)
   );

   assign state = curState;

   // Main sequencer. Every output is registered and defaults to idle each
   // cycle, so cnt_load and cnt_en are single-cycle pulses and never share
   // a cycle because they come from mutually exclusive branches. Entering
   // LOAD captures preset, dir and mode_bcd together; cnt_updown and
   // cnt_mode are touched nowhere else, so later changes on dir or
   // mode_bcd are ignored until the next load. On a tick in RUN the ones
   // digit always steps and the tens digit steps only when ones is about to
   // wrap; the counters' flags cannot move between the tick and the enable
   // because nothing else steps them. When both digits already sit at the
   // terminal value the tick moves to EXPIRED instead, so there is no wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         curState     <= IDLE;
         cnt_load     <= 1'b0;
         cnt_load_val <= 8'h00;
         cnt_en       <= 2'b00;
         cnt_updown   <= 1'b0;
         cnt_mode     <= 1'b0;
         expired      <= 1'b0;
      end else begin
         cnt_load     <= 1'b0;
         cnt_load_val <= 8'h00;
         cnt_en       <= 2'b00;
         expired      <= 1'b0;
         case (curState)
            IDLE: begin
               if (!clear && start) begin
                  curState     <= LOAD;
                  cnt_load     <= 1'b1;
                  cnt_load_val <= presetLoad;
                  cnt_updown   <= dir;
                  cnt_mode     <= mode_bcd;
               end
            end
            LOAD: begin
               if (clear) begin
                  curState     <= IDLE;
                  cnt_load     <= 1'b1;
                  cnt_load_val <= CLEAR_VAL;
               end else begin
                  curState <= RUN;
               end
            end
            RUN: begin
               if (clear) begin
                  curState     <= IDLE;
                  cnt_load     <= 1'b1;
                  cnt_load_val <= CLEAR_VAL;
               end else if (start) begin
                  curState     <= LOAD;
                  cnt_load     <= 1'b1;
                  cnt_load_val <= presetLoad;
                  cnt_updown   <= dir;
                  cnt_mode     <= mode_bcd;
               end else if (pause) begin
                  curState <= PAUSE;
               end else if (tick) begin
                  if (cnt_done == DONE_BOTH) begin
                     curState <= EXPIRED;
                     expired  <= 1'b1;
                  end else begin
                     cnt_en <= {cnt_done[0], 1'b1};
                  end
               end
            end
            PAUSE: begin
               if (clear) begin
                  curState     <= IDLE;
                  cnt_load     <= 1'b1;
                  cnt_load_val <= CLEAR_VAL;
               end else if (start) begin
                  curState <= RUN;
               end
            end
            EXPIRED: begin
               if (clear) begin
                  curState     <= IDLE;
                  cnt_load     <= 1'b1;
                  cnt_load_val <= CLEAR_VAL;
               end else if (start) begin
                  curState     <= LOAD;
                  cnt_load     <= 1'b1;
                  cnt_load_val <= presetLoad;
                  cnt_updown   <= dir;
                  cnt_mode     <= mode_bcd;
               end else begin
                  expired <= 1'b1;
               end
            end
            default: begin
               curState <= IDLE;
            end
         endcase
      end
   end

endmodule
